// File: rtl/addr_gen_2d_stream.sv
// addr_gen_2d_stream: raster-scan address generator with a 2-stage multiply/add pipeline
// and valid/ready output. Define ADDR_GEN_STRIDE_EN to add per-scan col_step/row_step inputs.
module addr_gen_2d_stream #(
    parameter int AW       = 25,
    parameter int DW       = 15,
    parameter int MAX_STEP = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [DW-1:0] line_width,
    input  logic [DW-1:0] num_rows,
    input  logic [DW-1:0] num_cols,
`ifdef ADDR_GEN_STRIDE_EN
    input  logic [$clog2(MAX_STEP+1)-1:0] col_step,
    input  logic [$clog2(MAX_STEP+1)-1:0] row_step,
`endif
    output logic [AW-1:0] addr,
    output logic          addr_valid,
    input  logic          addr_ready,
    output logic          last_col,
    output logic          last,
    output logic          busy,
    output logic          done
);
    localparam int SW  = $clog2(MAX_STEP + 1);
    localparam int PW  = DW + SW;   // position = beat count * step
    localparam int PRW = PW + DW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  base_q, base_d;
    logic [DW-1:0]  lw_q, lw_d, rows_q, rows_d, cols_q, cols_d;
    logic [SW-1:0]  col_step_q, col_step_d, row_step_q, row_step_d;
    logic [DW-1:0]  col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
    logic [PW-1:0]  col_pos_q, col_pos_d, row_pos_q, row_pos_d;
    logic           vld_p1_q, vld_p1_d;
    logic [PRW-1:0] prod_p1_q, prod_p1_d;
    logic [PW-1:0]  col_p1_q, col_p1_d;
    logic           last_col_p1_q, last_col_p1_d, last_p1_q, last_p1_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           addr_valid_q, addr_valid_d, last_col_q, last_col_d, last_q, last_d;
    logic           busy_q, busy_d, done_q, done_d;

    logic s2_accept, s1_accept, issue, at_last_col, at_last_row;

    assign s2_accept   = !addr_valid_q || addr_ready;
    assign s1_accept   = !vld_p1_q || s2_accept;
    assign issue       = (state_q == RUN) && s1_accept;
    assign at_last_col = (col_cnt_q == cols_q - DW'(1));
    assign at_last_row = (row_cnt_q == rows_q - DW'(1));

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        lw_d          = lw_q;
        rows_d        = rows_q;
        cols_d        = cols_q;
        col_step_d    = col_step_q;
        row_step_d    = row_step_q;
        col_cnt_d     = col_cnt_q;
        row_cnt_d     = row_cnt_q;
        col_pos_d     = col_pos_q;
        row_pos_d     = row_pos_q;
        vld_p1_d      = vld_p1_q;
        prod_p1_d     = prod_p1_q;
        col_p1_d      = col_p1_q;
        last_col_p1_d = last_col_p1_q;
        last_p1_d     = last_p1_q;
        addr_d        = addr_q;
        addr_valid_d  = addr_valid_q;
        last_col_d    = last_col_q;
        last_d        = last_q;
        busy_d        = busy_q;
        done_d        = 1'b0;

        // stage 2: base + row product + column offset
        if (vld_p1_q && s2_accept) begin
            addr_valid_d = 1'b1;
            addr_d       = base_q + AW'(prod_p1_q) + AW'(col_p1_q);
            last_col_d   = last_col_p1_q;
            last_d       = last_p1_q;
        end else if (addr_ready) begin
            addr_valid_d = 1'b0;
        end

        // stage 1: row multiply; counters move only when this stage loads
        if (issue) begin
            vld_p1_d      = 1'b1;
            prod_p1_d     = PRW'(row_pos_q) * PRW'(lw_q);
            col_p1_d      = col_pos_q;
            last_col_p1_d = at_last_col;
            last_p1_d     = at_last_col && at_last_row;
            if (at_last_col) begin
                col_cnt_d = '0;
                col_pos_d = '0;
                row_cnt_d = row_cnt_q + DW'(1);
                row_pos_d = row_pos_q + PW'(row_step_q);
            end else begin
                col_cnt_d = col_cnt_q + DW'(1);
                col_pos_d = col_pos_q + PW'(col_step_q);
            end
        end else if (s2_accept) begin
            vld_p1_d = 1'b0;
        end

        case (state_q)
            IDLE: if (start) begin
                base_d    = base_addr;
                lw_d      = line_width;
                rows_d    = num_rows;
                cols_d    = num_cols;
                col_cnt_d = '0;
                row_cnt_d = '0;
                col_pos_d = '0;
                row_pos_d = '0;
`ifdef ADDR_GEN_STRIDE_EN
                col_step_d = (col_step == '0) ? SW'(1) : col_step;
                row_step_d = (row_step == '0) ? SW'(1) : row_step;
`else
                col_step_d = SW'(1);
                row_step_d = SW'(1);
`endif
                if (num_rows != '0 && num_cols != '0) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            RUN: if (issue && at_last_col && at_last_row) state_d = DRAIN;
            DRAIN: if (addr_valid_q && addr_ready && last_q) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            base_q        <= '0;
            lw_q          <= '0;
            rows_q        <= '0;
            cols_q        <= '0;
            col_step_q    <= '0;
            row_step_q    <= '0;
            col_cnt_q     <= '0;
            row_cnt_q     <= '0;
            col_pos_q     <= '0;
            row_pos_q     <= '0;
            vld_p1_q      <= 1'b0;
            prod_p1_q     <= '0;
            col_p1_q      <= '0;
            last_col_p1_q <= 1'b0;
            last_p1_q     <= 1'b0;
            addr_q        <= '0;
            addr_valid_q  <= 1'b0;
            last_col_q    <= 1'b0;
            last_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            lw_q          <= lw_d;
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            col_step_q    <= col_step_d;
            row_step_q    <= row_step_d;
            col_cnt_q     <= col_cnt_d;
            row_cnt_q     <= row_cnt_d;
            col_pos_q     <= col_pos_d;
            row_pos_q     <= row_pos_d;
            vld_p1_q      <= vld_p1_d;
            prod_p1_q     <= prod_p1_d;
            col_p1_q      <= col_p1_d;
            last_col_p1_q <= last_col_p1_d;
            last_p1_q     <= last_p1_d;
            addr_q        <= addr_d;
            addr_valid_q  <= addr_valid_d;
            last_col_q    <= last_col_d;
            last_q        <= last_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign addr       = addr_q;
    assign addr_valid = addr_valid_q;
    assign last_col   = last_col_q;
    assign last       = last_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_addr_gen_2d_stream.sv
// Bench for addr_gen_2d_stream: randomized scans checked against a nested-loop address model.
module tb_addr_gen_2d_stream;
    localparam int AW       = 25;
    localparam int DW       = 15;
    localparam int MAX_STEP = 4;
    localparam int SW       = $clog2(MAX_STEP + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [DW-1:0] line_width = '0;
    logic [DW-1:0] num_rows = '0;
    logic [DW-1:0] num_cols = '0;
`ifdef ADDR_GEN_STRIDE_EN
    logic [SW-1:0] col_step = '0;
    logic [SW-1:0] row_step = '0;
`endif
    logic [AW-1:0] addr;
    logic          addr_valid;
    logic          addr_ready = 1'b0;
    logic          last_col;
    logic          last;
    logic          busy;
    logic          done;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [AW-1:0] a;
        bit            lc;
        bit            l;
    } beat_t;

    addr_gen_2d_stream #(.AW(AW), .DW(DW), .MAX_STEP(MAX_STEP)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .line_width(line_width), .num_rows(num_rows), .num_cols(num_cols),
`ifdef ADDR_GEN_STRIDE_EN
        .col_step(col_step), .row_step(row_step),
`endif
        .addr(addr), .addr_valid(addr_valid), .addr_ready(addr_ready),
        .last_col(last_col), .last(last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // mode 0: ready high, 1: ready pattern 1,0,0 repeating, 2: random ready
    task automatic do_scan(input string name, input logic [AW-1:0] b, input logic [DW-1:0] lw,
                           input int nr, input int nc, input int cstep, input int rstep,
                           input int mode, input bit poke_start);
        beat_t         exp_q[$];
        beat_t         bt;
        int            cs, rs, got, idx, done_at, budget;
        bit            stalled, seen_valid, finished, exp_busy, exp_done;
        logic [AW-1:0] held;
        cs = (cstep == 0) ? 1 : cstep;
        rs = (rstep == 0) ? 1 : rstep;
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                bt.a  = AW'(longint'(b) + longint'(r * rs) * longint'(lw) + longint'(c * cs));
                bt.lc = (c == nc - 1);
                bt.l  = (c == nc - 1) && (r == nr - 1);
                exp_q.push_back(bt);
            end
        end

        @(negedge clk);
        base_addr  = b;
        line_width = lw;
        num_rows   = DW'(nr);
        num_cols   = DW'(nc);
`ifdef ADDR_GEN_STRIDE_EN
        col_step   = SW'(cstep);
        row_step   = SW'(rstep);
`endif
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;

        done_at    = (exp_q.size() == 0) ? 0 : -1;
        budget     = 40 + 4 * exp_q.size();
        idx        = 0;
        got        = 0;
        stalled    = 1'b0;
        seen_valid = 1'b0;
        finished   = 1'b0;
        held       = '0;
        while (!finished) begin
            base_addr  = AW'($urandom);
            line_width = DW'($urandom);
            num_rows   = DW'($urandom);
            num_cols   = DW'($urandom);
            start      = poke_start && (idx == 2);
            case (mode)
                0:       addr_ready = 1'b1;
                1:       addr_ready = (idx % 3 == 0);
                default: addr_ready = 1'($urandom_range(0, 1));
            endcase

            vectors++;
            if (addr_valid) begin
                if (got >= exp_q.size()) begin
                    errors++;
                    $display("FAIL %s extra_beat: idx=%0d addr=%h beats expected %0d", name, idx, addr, exp_q.size());
                end else begin
                    if (!seen_valid && idx != 2) begin
                        errors++;
                        $display("FAIL %s latency: first valid at idx %0d, required 2", name, idx);
                    end
                    seen_valid = 1'b1;
                    vectors++;
                    if (addr !== exp_q[got].a || last_col !== exp_q[got].lc || last !== exp_q[got].l) begin
                        errors++;
                        $display("FAIL %s beat%0d: addr=%h last_col=%b last=%b, required addr=%h last_col=%b last=%b",
                                 name, got, addr, last_col, last, exp_q[got].a, exp_q[got].lc, exp_q[got].l);
                    end
                    if (stalled && addr !== held) begin
                        errors++;
                        $display("FAIL %s stall_hold: addr=%h, required %h", name, addr, held);
                    end
                    if (addr_ready) begin
                        if (exp_q[got].l) done_at = idx + 1;
                        got++;
                        stalled = 1'b0;
                    end else begin
                        stalled = 1'b1;
                        held    = addr;
                    end
                end
            end else if (stalled) begin
                errors++;
                $display("FAIL %s stall_drop: addr_valid=0 during stall, required 1", name);
                stalled = 1'b0;
            end else if (!seen_valid && idx == 2 && exp_q.size() != 0) begin
                errors++;
                $display("FAIL %s latency: addr_valid=0 at idx 2, required 1", name);
            end

            exp_done = (idx == done_at);
            exp_busy = (exp_q.size() != 0) && (done_at < 0 || idx < done_at);
            vectors++;
            if (done !== exp_done || busy !== exp_busy) begin
                errors++;
                $display("FAIL %s ctrl idx%0d: done=%b busy=%b, required done=%b busy=%b",
                         name, idx, done, busy, exp_done, exp_busy);
            end
            if (idx == done_at) begin
                finished = 1'b1;
            end else if (idx >= budget) begin
                errors++;
                $display("FAIL %s timeout: no done after %0d cycles, beats %0d of %0d", name, idx, got, exp_q.size());
                finished = 1'b1;
            end
            idx++;
            @(negedge clk);
        end
        start      = 1'b0;
        addr_ready = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || addr_valid !== 1'b0 || got != exp_q.size()) begin
            errors++;
            $display("FAIL %s end_state: busy=%b done=%b addr_valid=%b beats=%0d, required 0 0 0 beats=%0d",
                     name, busy, done, addr_valid, got, exp_q.size());
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({addr, addr_valid, last_col, last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_init: addr=%h valid=%b lc=%b last=%b busy=%b done=%b, required all 0",
                     addr, addr_valid, last_col, last, busy, done);
        end
        @(negedge clk);
        reset_n    = 1'b1;
        base_addr  = AW'(25'h0000123);
        line_width = DW'(16);
        num_rows   = DW'(4);
        num_cols   = DW'(4);
        addr_ready = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (addr_valid !== 1'b1 || busy !== 1'b1 || addr !== 25'h0000123) begin
            errors++;
            $display("FAIL reset_prescan: valid=%b busy=%b addr=%h, required 1 1 0000123", addr_valid, busy, addr);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({addr, addr_valid, last_col, last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_midscan: addr=%h valid=%b lc=%b last=%b busy=%b done=%b, required all 0",
                     addr, addr_valid, last_col, last, busy, done);
        end
        @(negedge clk);
        reset_n    = 1'b1;
        addr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0 || addr_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle%0d: busy=%b done=%b valid=%b, required 0 0 0", i, busy, done, addr_valid);
            end
        end
        addr_ready = 1'b0;
    endtask

    task automatic test_basic();
        do_scan("basic", 25'h0000100, DW'(64), 2, 3, 1, 1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_scan("backpressure", 25'h0000100, DW'(64), 2, 3, 1, 1, 1, 1'b0);
    endtask

    task automatic test_empty();
        do_scan("empty_rows", 25'h0000040, DW'(8), 0, 5, 1, 1, 0, 1'b0);
        do_scan("empty_cols", 25'h0000040, DW'(8), 3, 0, 1, 1, 0, 1'b0);
    endtask

    task automatic test_wrap();
        do_scan("wrap", 25'h1FFFFFE, DW'(1), 1, 4, 1, 1, 0, 1'b0);
    endtask

    task automatic test_single();
        do_scan("single", 25'h0ABCDEF, DW'(100), 1, 1, 1, 1, 2, 1'b1);
    endtask

`ifdef ADDR_GEN_STRIDE_EN
    task automatic test_stride();
        do_scan("stride", 25'h0000000, DW'(10), 2, 2, 2, 3, 0, 1'b1);
        do_scan("stride_zero", 25'h0000200, DW'(7), 2, 3, 0, 0, 1, 1'b0);
    endtask
`endif

    task automatic test_back_to_back();
        for (int i = 0; i < 14; i++) begin
            int cs, rs;
`ifdef ADDR_GEN_STRIDE_EN
            cs = $urandom_range(0, MAX_STEP);
            rs = $urandom_range(0, MAX_STEP);
`else
            cs = 1;
            rs = 1;
`endif
            do_scan($sformatf("random%0d", i), AW'($urandom), DW'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 6), cs, rs,
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_wrap();
        test_single();
`ifdef ADDR_GEN_STRIDE_EN
        test_stride();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
